// File: rtl/eca_stepper.sv
// eca_stepper: elementary cellular-automaton engine with run controller.
// Applies a runtime-selected 8-bit Wolfram rule to a WIDTH-cell array,
// with zero or wrap-around boundaries, for a requested number of generations.
// Optional build macro: ECA_EARLY_STOP_EN -- end a run at the first fixed point.
module eca_stepper #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [7:0]       rule,
    input  logic             wrap,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] gen_count,
    output logic             stable
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [7:0]       rule_r;
    logic             wrap_r;
    logic [CNT_W-1:0] remaining;

    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] nxt;
    logic             fixed_pt;
    logic [CNT_W-1:0] gen_inc;

    // Array padded with the boundary cells: ext[0] is q[-1], ext[WIDTH+1] is q[WIDTH]
    always_comb begin
        ext = {wrap_r & q[0], q, wrap_r & q[WIDTH-1]};
    end

    // Next generation: each cell looks up the latched rule with its {L,C,R} neighbourhood
    always_comb begin
        nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            nxt[i] = rule_r[{ext[i+2], ext[i+1], ext[i]}];
        end
    end

    // Fixed-point detect and saturating generation increment
    always_comb begin
        fixed_pt = (nxt == q);
        gen_inc  = (gen_count == '1) ? gen_count : gen_count + CNT_W'(1);
    end

    // Run controller: load/start handling, generation stepping, status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            q         <= '0;
            gen_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stable    <= 1'b0;
            rule_r    <= '0;
            wrap_r    <= 1'b0;
            remaining <= '0;
        end else if (load) begin
            state     <= IDLE;
            q         <= data;
            gen_count <= '0;
            stable    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rule_r    <= rule;
                        wrap_r    <= wrap;
                        remaining <= steps;
                        if (steps == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
`ifdef ECA_EARLY_STOP_EN
                    // A fixed point ends the run without consuming a generation
                    if (fixed_pt) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        stable <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        q         <= nxt;
                        gen_count <= gen_inc;
                        remaining <= remaining - CNT_W'(1);
                        if (fixed_pt) begin
                            stable <= 1'b1;
                        end
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eca_stepper.sv
// tb_eca_stepper: directed and randomized checks of eca_stepper against a
// generation-level behavioural model. Honours ECA_EARLY_STOP_EN if defined.
module tb_eca_stepper;

    localparam int unsigned W  = 512;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          reset;
    logic          load;
    logic [W-1:0]  data;
    logic [7:0]    rule;
    logic          wrap;
    logic          start;
    logic [CW-1:0] steps;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;
    logic [CW-1:0] gen_count;
    logic          stable;

    int vecs = 0;
    int errs = 0;

    eca_stepper #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data     (data),
        .rule     (rule),
        .wrap     (wrap),
        .start    (start),
        .steps    (steps),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .gen_count(gen_count),
        .stable   (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One generation from the rule table, neighbours taken by plain index arithmetic
    function automatic logic [W-1:0] ca_next(input logic [W-1:0] cur, input logic [7:0] r,
                                             input bit wr);
        logic [W-1:0] res;
        int l, c, rr;
        res = '0;
        for (int i = 0; i < int'(W); i++) begin
            c  = int'(cur[i]);
            l  = (i == int'(W) - 1) ? (wr ? int'(cur[0]) : 0) : int'(cur[i+1]);
            rr = (i == 0) ? (wr ? int'(cur[W-1]) : 0) : int'(cur[i-1]);
            res[i] = r[4*l + 2*c + rr];
        end
        return res;
    endfunction

    // Behavioural model: m_rem != 0 means a run is in progress
    logic [W-1:0]  m_q;
    logic [W-1:0]  m_nxt;
    logic [CW-1:0] m_gen;
    logic [CW-1:0] m_rem;
    logic [7:0]    m_rule;
    bit            m_wrap;
    bit            m_done;
    bit            m_stable;
    bit            model_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q = '0; m_gen = '0; m_rem = '0; m_rule = '0; m_wrap = 1'b0;
            m_done = 1'b0; m_stable = 1'b0;
        end else if (load) begin
            m_q = data; m_gen = '0; m_rem = '0; m_done = 1'b0; m_stable = 1'b0;
        end else if (m_rem == '0) begin
            if (start) begin
                m_rule = rule;
                m_wrap = wrap;
                m_rem  = steps;
                m_done = (steps == '0);
            end
        end else begin
            m_nxt = ca_next(m_q, m_rule, m_wrap);
            if (m_nxt == m_q) begin
                m_stable = 1'b1;
`ifdef ECA_EARLY_STOP_EN
                m_rem  = '0;
                m_done = 1'b1;
`endif
            end
            if (m_rem != '0) begin
                m_q = m_nxt;
                if (m_gen != '1) m_gen++;
                m_rem--;
                if (m_rem == '0) m_done = 1'b1;
            end
        end
        model_on = 1'b1;
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (model_on) begin
            chk("q",      q,             m_q);
            chk("busy",   W'(busy),      W'(m_rem != '0));
            chk("done",   W'(done),      W'(m_done));
            chk("gen",    W'(gen_count), W'(m_gen));
            chk("stable", W'(stable),    W'(m_stable));
        end
    end

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int k = 0; k < int'(W / 32); k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_load(input logic [W-1:0] d);
        load = 1'b1; data = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] r, input logic wr, input logic [CW-1:0] n);
        start = 1'b1; rule = r; wrap = wr; steps = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] e;
        reset = 1'b1; load = 1'b0; start = 1'b0; data = '0; rule = '0; wrap = 1'b0; steps = '0;
        repeat (2) @(negedge clk);
        chk("rst_q",     q,             '0);
        chk("rst_flags", W'({busy, done, stable}), '0);
        chk("rst_gen",   W'(gen_count), '0);
        reset = 1'b0;

        // Rule 110 growth from a single cell
        do_load(W'(1));
        do_start(8'h6E, 1'b0, CW'(3));
        chk("r110_busy", W'(busy), W'(1));
        @(negedge clk); chk("r110_g1", q, W'(3));
        @(negedge clk); chk("r110_g2", q, W'(7));
        @(negedge clk); chk("r110_g3", q, W'(13));
        chk("r110_done",   W'({busy, done}), W'(1));
        chk("r110_gen",    W'(gen_count),    W'(3));
        chk("r110_stable", W'(stable),       W'(0));

        // Boundary handling, rule 90
        do_load(W'(1));
        do_start(8'h5A, 1'b1, CW'(1));
        @(negedge clk);
        e = '0; e[1] = 1'b1; e[W-1] = 1'b1;
        chk("wrap1_q", q, e);
        do_load(W'(1));
        do_start(8'h5A, 1'b0, CW'(1));
        @(negedge clk);
        chk("wrap0_q", q, W'(2));

        // Zero-step run
        do_load(W'(8'hAB));
        do_start(8'h6E, 1'b0, CW'(0));
        chk("zero_done", W'({busy, done}), W'(1));
        chk("zero_q",    q,                W'(8'hAB));
        chk("zero_gen",  W'(gen_count),    W'(0));

        // Abort with simultaneous load and start
        do_load(rand_data());
        do_start(8'($urandom), 1'($urandom), CW'(100));
        repeat (4) @(negedge clk);
        load = 1'b1; start = 1'b1; data = W'(8'hF0); steps = CW'(7);
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        chk("abort_q",     q,                W'(8'hF0));
        chk("abort_flags", W'({busy, done}), W'(0));
        chk("abort_gen",   W'(gen_count),    W'(0));

        // Fixed point under rule 0
        do_load('0);
        do_start(8'h00, 1'b0, CW'(5));
`ifdef ECA_EARLY_STOP_EN
        @(negedge clk);
        chk("fix_done", W'({busy, done}), W'(1));
        chk("fix_gen",  W'(gen_count),    W'(0));
`else
        repeat (4) @(negedge clk);
        chk("fix_busy", W'(busy), W'(1));
        @(negedge clk);
        chk("fix_done", W'({busy, done}), W'(1));
        chk("fix_gen",  W'(gen_count),    W'(5));
`endif
        chk("fix_stable", W'(stable), W'(1));
        chk("fix_q",      q,          '0);

        // Reset mid-run, then a fresh run from the cleared array
        do_load(rand_data());
        do_start(8'h6E, 1'b1, CW'(50));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rrst_q",     q,                        '0);
        chk("rrst_flags", W'({busy, done, stable}), '0);
        chk("rrst_gen",   W'(gen_count),            '0);
        do_start(8'hFF, 1'b0, CW'(1));
        @(negedge clk);
        chk("fresh_q",   q,                '1);
        chk("fresh_gen", W'(gen_count),    W'(1));
        chk("fresh_st",  W'({busy, done, stable}), W'(2));

        // Randomized traffic, checked each cycle by the compare process
        for (int n = 0; n < 600; n++) begin
            int sel;
            reset = ($urandom_range(0, 79) == 0);
            load  = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 3) == 0);
            data  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : rand_data();
            sel   = int'($urandom_range(0, 7));
            case (sel)
                0:       rule = 8'hCC;
                1:       rule = 8'h00;
                2:       rule = 8'h6E;
                3:       rule = 8'hFF;
                default: rule = 8'($urandom);
            endcase
            wrap  = 1'($urandom);
            steps = CW'($urandom_range(0, 12));
            @(negedge clk);
        end
        reset = 1'b0; load = 1'b0; start = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        errs++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $fatal(1, "timeout");
    end

endmodule
